// File: rtl/product_accumulator.sv
// product_accumulator: sums a run of `len` unsigned 16-bit products into an
// ACC_W-bit accumulator, then presents the result with a valid/ready handshake.
// Optional build macro PRODUCT_ACCUMULATOR_SATURATE_EN: when defined, an add
// that carries out clamps the accumulator to all-ones instead of wrapping.
module product_accumulator #(
   parameter int ACC_W = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       len,
   input  logic [15:0]      product,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [ACC_W-1:0] sum,
   output logic             sum_valid,
   input  logic             sum_ready,
   output logic             busy,
   output logic             ovf
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   logic [ACC_W-1:0] acc_r;
   logic [3:0]       remaining_r;
   logic             ovf_r;
   logic             in_ready_r;
   logic             sum_valid_r;
   logic             busy_r;

   logic [ACC_W:0]   add_s;
   logic [ACC_W-1:0] acc_next_s;

   // Accumulator plus zero-extended product, with the carry kept in the top bit.
   function automatic logic [ACC_W:0] add_ext(input logic [ACC_W-1:0] a,
                                              input logic [15:0]      p);
      add_ext = {1'b0, a} + {{(ACC_W-15){1'b0}}, p};
   endfunction

   // Reduce the widened sum back to ACC_W bits, clamping or wrapping on carry.
   function automatic logic [ACC_W-1:0] fold(input logic [ACC_W:0] s);
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
      if (s[ACC_W]) begin
         fold = {ACC_W{1'b1}};
      end else begin
         fold = s[ACC_W-1:0];
      end
`else
      fold = s[ACC_W-1:0];
`endif
   endfunction

   // Datapath for one transfer: next accumulator value and its carry.
   always_comb begin
      add_s      = add_ext(acc_r, product);
      acc_next_s = fold(add_s);
   end

   // Control FSM with registered handshake/status flags and accumulator state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         acc_r       <= {ACC_W{1'b0}};
         remaining_r <= 4'd0;
         ovf_r       <= 1'b0;
         in_ready_r  <= 1'b0;
         sum_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  acc_r       <= {ACC_W{1'b0}};
                  ovf_r       <= 1'b0;
                  remaining_r <= len;
                  busy_r      <= 1'b1;
                  if (len != 4'd0) begin
                     state_r    <= ACC;
                     in_ready_r <= 1'b1;
                  end else begin
                     // Empty run: report a zero sum straight away.
                     state_r     <= DONE;
                     sum_valid_r <= 1'b1;
                  end
               end
            end
            ACC: begin
               // in_ready is high throughout ACC, so in_valid alone marks a transfer.
               if (in_valid) begin
                  acc_r       <= acc_next_s;
                  ovf_r       <= ovf_r | add_s[ACC_W];
                  remaining_r <= remaining_r - 4'd1;
                  if (remaining_r == 4'd1) begin
                     state_r     <= DONE;
                     in_ready_r  <= 1'b0;
                     sum_valid_r <= 1'b1;
                  end
               end
            end
            DONE: begin
               // start is not looked at here, so a start overlapping the
               // handshake does not launch a run.
               if (sum_ready) begin
                  state_r     <= IDLE;
                  sum_valid_r <= 1'b0;
                  busy_r      <= 1'b0;
               end
            end
            default: begin
               state_r     <= IDLE;
               in_ready_r  <= 1'b0;
               sum_valid_r <= 1'b0;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign sum       = acc_r;
   assign sum_valid = sum_valid_r;
   assign busy      = busy_r;
   assign ovf       = ovf_r;

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator. Two instances (ACC_W=20 and
// ACC_W=16) share all inputs; a plain-arithmetic model predicts sum and ovf.
module tb_product_accumulator;

   logic        clk;
   logic        rst;
   logic        start;
   logic [3:0]  len;
   logic [15:0] product;
   logic        in_valid;
   logic        sum_ready;

   logic        in_ready_a, sum_valid_a, busy_a, ovf_a;
   logic [19:0] sum_a;
   logic        in_ready_b, sum_valid_b, busy_b, ovf_b;
   logic [15:0] sum_b;

   int checks = 0;
   int passes = 0;

   logic [15:0] prods [0:15];
   int          gaps  [0:15];

   product_accumulator #(.ACC_W(20)) dut_a (
      .clk(clk), .rst(rst), .start(start), .len(len), .product(product),
      .in_valid(in_valid), .in_ready(in_ready_a), .sum(sum_a),
      .sum_valid(sum_valid_a), .sum_ready(sum_ready), .busy(busy_a), .ovf(ovf_a)
   );

   product_accumulator #(.ACC_W(16)) dut_b (
      .clk(clk), .rst(rst), .start(start), .len(len), .product(product),
      .in_valid(in_valid), .in_ready(in_ready_b), .sum(sum_b),
      .sum_valid(sum_valid_b), .sum_ready(sum_ready), .busy(busy_b), .ovf(ovf_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected ovf: some add carried iff the true total reaches 2^w.
   function automatic logic exp_ovf(input longint total, input int w);
      return (total >= (64'sd1 <<< w));
   endfunction

   // Expected sum: the true total reduced to w bits (clamped or wrapped).
   function automatic logic [31:0] exp_sum(input longint total, input int w);
      longint m;
      m = 64'sd1 <<< w;
      if (total >= m) begin
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
         return 32'(m - 1);
`else
         return 32'(total % m);
`endif
      end
      return 32'(total);
   endfunction

   // One complete run: start, n transfers with gaps[k] stall cycles before
   // transfer k, hold cycles with sum_ready low, then the handshake.
   task automatic run(input int n, input int hold, input bit start_hold);
      longint total;
      logic [31:0] ea, eb;
      logic oa, ob;
      total = 0;
      start = 1'b1;
      len   = 4'(n);
      step();
      start = 1'b0;
      check("busy_after_start", busy_a, 1'b1);
      for (int k = 0; k < n; k++) begin
         for (int g = 0; g < gaps[k]; g++) begin
            in_valid = 1'b0;
            product  = 16'($urandom);
            start    = 1'($urandom);
            len      = 4'($urandom);
            check("stall_in_ready", in_ready_a, 1'b1);
            check("stall_no_sum_valid", sum_valid_a, 1'b0);
            step();
         end
         start    = 1'b0;
         in_valid = 1'b1;
         product  = prods[k];
         check("acc_in_ready", in_ready_b, 1'b1);
         step();
         total += longint'(prods[k]);
         in_valid = 1'b0;
      end
      ea = exp_sum(total, 20);
      eb = exp_sum(total, 16);
      oa = exp_ovf(total, 20);
      ob = exp_ovf(total, 16);
      check("done_sum_valid_a", sum_valid_a, 1'b1);
      check("done_sum_valid_b", sum_valid_b, 1'b1);
      check("done_in_ready", in_ready_a, 1'b0);
      check("done_busy", busy_a, 1'b1);
      check("sum_a", sum_a, ea);
      check("ovf_a", ovf_a, oa);
      check("sum_b", sum_b, eb);
      check("ovf_b", ovf_b, ob);
      sum_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
         step();
         check("hold_sum_valid", sum_valid_a, 1'b1);
         check("hold_sum_a", sum_a, ea);
         check("hold_sum_b", sum_b, eb);
      end
      sum_ready = 1'b1;
      start     = start_hold;
      step();
      sum_ready = 1'b0;
      check("idle_sum_valid", sum_valid_a, 1'b0);
      check("idle_busy", busy_a, 1'b0);
      check("idle_in_ready", in_ready_a, 1'b0);
      check("idle_sum_retained", sum_b, eb);
      check("idle_ovf_retained", ovf_b, ob);
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; len = 4'd0; product = 16'd0;
      in_valid = 1'b0; sum_ready = 1'b0;
      step();
      step();
      check("rst_in_ready", in_ready_a, 1'b0);
      check("rst_sum_valid", sum_valid_a, 1'b0);
      check("rst_busy", busy_a, 1'b0);
      check("rst_ovf", ovf_a, 1'b0);
      check("rst_sum", sum_a, 32'd0);
      rst = 1'b0;
      step();

      // Three products, back to back.
      prods[0] = 16'h0006; prods[1] = 16'h00FF; prods[2] = 16'hFE01;
      for (int i = 0; i < 16; i++) gaps[i] = 0;
      run(3, 1, 1'b0);
      check("basic_sum_literal", sum_a, 32'h0FF06);

      // Empty run.
      run(0, 1, 1'b0);

      // Stalled input and a long sum_ready hold.
      prods[0] = 16'h0010; prods[1] = 16'h0020;
      gaps[0] = 0; gaps[1] = 2;
      run(2, 5, 1'b0);
      check("stall_sum_literal", sum_a, 32'h00030);
      gaps[1] = 0;

      // Carry out of the 16-bit instance; start held through the handshake.
      prods[0] = 16'hFFFF; prods[1] = 16'h0002;
      run(2, 0, 1'b1);
      check("ovf16_flag", ovf_b, 1'b1);
      step();
      check("start_ignored_stays_idle", busy_a, 1'b0);

      // Reset after one of four transfers, coinciding with a valid product.
      start = 1'b1; len = 4'd4;
      step();
      start = 1'b0; in_valid = 1'b1; product = 16'h0100;
      step();
      product = 16'h0200; rst = 1'b1;
      step();
      rst = 1'b0; in_valid = 1'b0;
      check("abort_busy", busy_a, 1'b0);
      check("abort_in_ready", in_ready_a, 1'b0);
      check("abort_sum_valid", sum_valid_a, 1'b0);
      check("abort_sum", sum_a, 32'd0);
      check("abort_ovf", ovf_a, 1'b0);
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'($urandom);
         step();
         check("abort_no_sum_valid", sum_valid_a, 1'b0);
      end
      in_valid = 1'b0;
      prods[0] = 16'h0005;
      run(1, 0, 1'b0);
      check("after_abort_sum", sum_a, 32'h00005);

      // Random runs: 8x8 products, random stalls and hold lengths.
      for (int r = 0; r < 25; r++) begin
         int n;
         n = $urandom_range(0, 15);
         for (int k = 0; k < 16; k++) begin
            prods[k] = 16'($urandom_range(0, 255) * $urandom_range(0, 255));
            gaps[k]  = $urandom_range(0, 2);
         end
         run(n, $urandom_range(0, 3), 1'($urandom));
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
